piso_rr_sched: RTL and testbench

Round-robin scheduler that shares one N-bit PISO shift register (load/shift control: 0 = load, 1 = shift, LSB first, registered serial output) between NREQ parallel-word requesters.
- Accepts one word per transaction over a valid/ready handshake.
- Sequences the PISO through one load cycle and W shift cycles.
- Re-times the PISO's serial output into a framed stream carrying valid, first, last and requester-ID sideband.
- Sits between the parallel producers and the single serial link.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_rr_sched_rr_arbiter.sv | 31 +++
 rtl/piso_rr_sched.sv | 127 ++++++++++++
 tb/tb_piso_rr_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the round-robin PISO scheduler.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam logic CTRL_LOAD  = 1'b0;
   localparam logic CTRL_SHIFT = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int max1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/piso_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            any
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/piso_rr_sched.sv
// Round-robin scheduler feeding one shared PISO; frames its serial output
// with valid/first/last/id sideband aligned to the PISO's registered bit.
module piso_rr_sched
   import piso_pkg::*;
#(
   parameter  int W    = 8,
   parameter  int NREQ = 4,
   localparam int IDW  = max1(clog2(NREQ)),
   localparam int CW   = max1(clog2(W))
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              piso_control,
   output logic [W-1:0]      piso_in,
   input  logic              piso_out,
   output logic              ser_data,
   output logic              ser_valid,
   output logic              ser_first,
   output logic              ser_last,
   output logic [IDW-1:0]    ser_id,
   output logic              busy
);

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  ser_id_q, ser_id_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [W-1:0]    hold_q, hold_d;
   logic            ser_valid_q, ser_valid_d;
   logic            ser_first_q, ser_first_d;
   logic            ser_last_q, ser_last_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic            any;
   logic [W-1:0]    sel_data;
   logic            last_bit;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign last_bit = (bit_cnt_q == CW'(W - 1));

   // grant is one-hot, so an AND-OR mux picks the winning word
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         sel_data = sel_data | ({W{grant[i]}} & req_data[i*W +: W]);
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      hold_d    = hold_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               hold_d   = sel_data;
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // PISO presents the shifted bit one cycle later, so framing lags SHIFT by one
      ser_valid_d = (state_q == ST_SHIFT);
      ser_first_d = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
      ser_last_d  = (state_q == ST_SHIFT) && last_bit;
      ser_id_d    = (state_q == ST_SHIFT) ? id_q : ser_id_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         hold_q      <= '0;
         bit_cnt_q   <= '0;
         ser_valid_q <= 1'b0;
         ser_first_q <= 1'b0;
         ser_last_q  <= 1'b0;
         ser_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         hold_q      <= hold_d;
         bit_cnt_q   <= bit_cnt_d;
         ser_valid_q <= ser_valid_d;
         ser_first_q <= ser_first_d;
         ser_last_q  <= ser_last_d;
         ser_id_q    <= ser_id_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE && !rst) ? grant : '0;
   assign piso_control = (state_q == ST_SHIFT) ? CTRL_SHIFT : CTRL_LOAD;
   assign piso_in      = (state_q == ST_IDLE) ? '0 : hold_q;
   assign busy         = (state_q != ST_IDLE);
   assign ser_data     = piso_out;
   assign ser_valid    = ser_valid_q;
   assign ser_first    = ser_first_q;
   assign ser_last     = ser_last_q;
   assign ser_id       = ser_id_q;

endmodule

// File: tb/tb_piso_rr_sched.sv
// Bench for piso_rr_sched with an attached PISO; a transaction-level model
// schedules every expected serial bit by absolute cycle number.
module tb_piso_rr_sched;

   localparam int W    = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              piso_control;
   logic [W-1:0]      piso_in;
   logic              piso_out;
   logic              ser_data, ser_valid, ser_first, ser_last;
   logic [IDW-1:0]    ser_id;
   logic              busy;

   always #5 clk = ~clk;

   // attached PISO: 0 = load, 1 = shift LSB first into a registered output
   logic [W-1:0] piso_sh;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         piso_sh  <= '0;
         piso_out <= 1'b0;
      end else if (piso_control) begin
         piso_out <= piso_sh[0];
         piso_sh  <= piso_sh >> 1;
      end else begin
         piso_sh  <= piso_in;
      end
   end

   piso_rr_sched #(.W(W), .NREQ(NREQ)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .piso_control (piso_control),
      .piso_in      (piso_in),
      .piso_out     (piso_out),
      .ser_data     (ser_data),
      .ser_valid    (ser_valid),
      .ser_first    (ser_first),
      .ser_last     (ser_last),
      .ser_id       (ser_id),
      .busy         (busy)
   );

   typedef struct {
      logic           d;
      logic           f;
      logic           l;
      logic [IDW-1:0] id;
   } frm_t;

   frm_t            exp_frm [int];
   int              cyc;
   int              m_ptr;
   int              m_free;
   logic [IDW-1:0]  m_id;
   int              total = 0;
   int              bad = 0;
   int              dut_gnt [$];
   logic [NREQ-1:0] oneshot;
   int              exp_ord3 [5] = '{0, 1, 2, 3, 0};
   int              exp_ord4 [4] = '{0, 2, 0, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_free = cyc;
      m_id   = '0;
      exp_frm.delete();
   endtask

   task automatic set_req(input int i, input logic [W-1:0] d);
      req_valid[i]       = 1'b1;
      req_data[i*W +: W] = d;
   endtask

   // one clock: check at the falling edge, advance the model, then move past the rising edge
   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] rdy_seen;
      logic [W-1:0]    wd;
      frm_t            nf;
      int              g;
      int              idx;
      @(negedge clk);
      exp_rdy = '0;
      g = -1;
      if (cyc >= m_free) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(cyc < m_free));
      if (exp_frm.exists(cyc)) begin
         m_id = exp_frm[cyc].id;
         chk("ser_valid", 32'(ser_valid), 32'(1));
         chk("ser_data", 32'(ser_data), 32'(exp_frm[cyc].d));
         chk("ser_first", 32'(ser_first), 32'(exp_frm[cyc].f));
         chk("ser_last", 32'(ser_last), 32'(exp_frm[cyc].l));
      end else begin
         chk("ser_valid_idle", 32'(ser_valid), 32'(0));
         chk("ser_first_idle", 32'(ser_first), 32'(0));
         chk("ser_last_idle", 32'(ser_last), 32'(0));
      end
      chk("ser_id", 32'(ser_id), 32'(m_id));
      if (g >= 0) begin
         wd = req_data[g*W +: W];
         for (int k = 0; k < W; k++) begin
            nf.d  = wd[k];
            nf.f  = (k == 0);
            nf.l  = (k == W - 1);
            nf.id = IDW'(g);
            exp_frm[cyc + 3 + k] = nf;
         end
         m_ptr  = (g + 1) % NREQ;
         m_free = cyc + W + 2;
      end
      for (int i = 0; i < NREQ; i++)
         if (req_ready[i]) dut_gnt.push_back(i);
      rdy_seen = req_ready;
      @(posedge clk);
      #1;
      cyc++;
      req_valid = req_valid & ~(rdy_seen & oneshot);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // reset applied mid-cycle; framing and busy must drop without a clock
   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ser_valid", 32'(ser_valid), 32'(0));
      chk("rst_ser_first", 32'(ser_first), 32'(0));
      chk("rst_ser_last", 32'(ser_last), 32'(0));
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      model_reset();
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      oneshot   = '0;
      cyc       = 0;
      #1;
      rst = 1'b1;
      #2;
      chk("init_req_ready", 32'(req_ready), 32'(0));
      chk("init_busy", 32'(busy), 32'(0));
      chk("init_ser_valid", 32'(ser_valid), 32'(0));
      chk("init_ser_first", 32'(ser_first), 32'(0));
      chk("init_ser_last", 32'(ser_last), 32'(0));
      chk("init_ser_id", 32'(ser_id), 32'(0));
      chk("init_piso_control", 32'(piso_control), 32'(0));
      chk("init_piso_in", 32'(piso_in), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // single request from requester 1
      dut_gnt.delete();
      set_req(1, 8'hA5);
      oneshot = 4'b0010;
      step();
      run(12);
      chk("single_gnt_cnt", 32'(dut_gnt.size()), 32'(1));
      if (dut_gnt.size() > 0) chk("single_gnt_id", 32'(dut_gnt[0]), 32'(1));

      // all four requesters continuously
      reset_pulse();
      dut_gnt.delete();
      oneshot = '0;
      set_req(0, 8'h11);
      set_req(1, 8'h22);
      set_req(2, 8'h33);
      set_req(3, 8'h44);
      run(41);
      req_valid = '0;
      run(12);
      chk("all4_gnt_cnt", 32'(dut_gnt.size()), 32'(5));
      for (int k = 0; k < 5 && k < dut_gnt.size(); k++)
         chk("all4_gnt_order", 32'(dut_gnt[k]), 32'(exp_ord3[k]));

      // fairness: req0 held, req2 raised while word 0 shifts; then pointer probe with req1
      reset_pulse();
      dut_gnt.delete();
      oneshot = '0;
      set_req(0, 8'h0F);
      run(4);
      set_req(2, 8'hF0);
      oneshot = 4'b0100;
      run(17);
      set_req(1, 8'h69);
      oneshot = 4'b0110;
      run(10);
      req_valid = '0;
      run(12);
      chk("fair_gnt_cnt", 32'(dut_gnt.size()), 32'(4));
      for (int k = 0; k < 4 && k < dut_gnt.size(); k++)
         chk("fair_gnt_order", 32'(dut_gnt[k]), 32'(exp_ord4[k]));

      // all-zero word, then idle
      set_req(3, 8'h00);
      oneshot = 4'b1000;
      step();
      run(15);

      // reset in cycle 5 of a transfer, then request right after release
      set_req(2, 8'h3C);
      oneshot = 4'b0100;
      run(5);
      reset_pulse();
      dut_gnt.delete();
      set_req(1, 8'hC3);
      set_req(3, 8'h81);
      oneshot = 4'b1010;
      step();
      if (dut_gnt.size() > 0) chk("post_rst_gnt", 32'(dut_gnt[0]), 32'(1));
      else chk("post_rst_gnt_cnt", 32'(dut_gnt.size()), 32'(1));
      run(24);

      // deassert after acceptance: one grant, full word
      dut_gnt.delete();
      set_req(1, 8'h96);
      oneshot = 4'b0010;
      step();
      run(13);
      chk("deassert_gnt_cnt", 32'(dut_gnt.size()), 32'(1));

      // random traffic
      oneshot = '0;
      repeat (400) begin
         req_valid = NREQ'($urandom);
         req_data  = 32'($urandom);
         step();
      end
      req_valid = '0;
      run(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
